sha256_round_ctrl: RTL and testbench

Iterative SHA-256 compression engine controller that processes one 512-bit message block in 64 single-cycle rounds.
- Owns the round counter, the 16-word message-schedule buffer, the K-constant table, working registers a..h and chaining state H0..H7.
- Sequences the shared round datapath: Ch via a prim_generic_ch instance, plus Maj, Σ0/Σ1 and σ0/σ1.
- Sits between the padding/block-feed logic (upstream) and the digest consumer (downstream).

---
 rtl/sha256_round_ctrl_if.sv | 21 ++
 rtl/sha256_round_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_round_ctrl_if.sv
// Block-feed and digest handshake bundle for the SHA-256 round controller.
// master = upstream/consumer side, slave = the compression engine.
interface sha256_round_ctrl_if;
  logic         block_valid_i;
  logic         block_ready_o;
  logic [511:0] block_i;
  logic         init_i;
  logic         busy_o;
  logic         digest_valid_o;
  logic [255:0] digest_o;

  modport master (
    output block_valid_i, block_i, init_i,
    input  block_ready_o, busy_o, digest_valid_o, digest_o
  );

  modport slave (
    input  block_valid_i, block_i, init_i,
    output block_ready_o, busy_o, digest_valid_o, digest_o
  );
endinterface

// File: rtl/sha256_round_ctrl.sv
// Iterative SHA-256 compression: one 512-bit block in Rounds single-cycle rounds,
// followed by a chaining-state update and a one-cycle digest_valid pulse.
module sha256_round_ctrl #(
  parameter int unsigned Rounds = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  sha256_round_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE} state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [5:0] LAST_ROUND = 6'(Rounds - 1);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic        dv_q;
  logic [31:0] w_q  [16];
  logic [31:0] wv_q [8];
  logic [31:0] h_q  [8];

  logic [31:0] w_d;
  logic [31:0] a_d;
  logic [31:0] e_d;
  logic [31:0] t1;
  logic [31:0] t2;
  logic [31:0] ch;
  logic [31:0] maj;
  logic [255:0] digest;

  prim_generic_ch #(.Width(32)) u_ch (
    .x_i  (wv_q[4]),
    .y_i  (wv_q[5]),
    .z_i  (wv_q[6]),
    .ch_o (ch)
  );

  // Buffer holds W[t-16..t-1] once t>=16, so the taps are fixed slots.
  always_comb begin
    if (cnt_q < 6'd16) begin
      w_d = w_q[0];
    end else begin
      w_d = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    end
    maj = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]);
    t1  = wv_q[7] + bsig1(wv_q[4]) + ch + K_TABLE[cnt_q] + w_d;
    t2  = bsig0(wv_q[0]) + maj;
    a_d = t1 + t2;
    e_d = wv_q[3] + t1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        wv_q[i] <= '0;
        h_q[i]  <= IV[i];
      end
    end else begin
      dv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.block_valid_i) begin
            for (int unsigned i = 0; i < 16; i++) w_q[i] <= bus.block_i[32*(15-i) +: 32];
            for (int unsigned i = 0; i < 8; i++) begin
              if (bus.init_i) begin
                wv_q[i] <= IV[i];
                h_q[i]  <= IV[i];
              end else begin
                wv_q[i] <= h_q[i];
              end
            end
            cnt_q   <= '0;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          for (int unsigned i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= w_d;
          wv_q[7] <= wv_q[6];
          wv_q[6] <= wv_q[5];
          wv_q[5] <= wv_q[4];
          wv_q[4] <= e_d;
          wv_q[3] <= wv_q[2];
          wv_q[2] <= wv_q[1];
          wv_q[1] <= wv_q[0];
          wv_q[0] <= a_d;
          cnt_q   <= cnt_q + 6'd1;
          if (cnt_q == LAST_ROUND) state_q <= UPDATE;
        end
        UPDATE: begin
          for (int unsigned i = 0; i < 8; i++) h_q[i] <= h_q[i] + wv_q[i];
          dv_q    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    digest = '0;
    for (int unsigned i = 0; i < 8; i++) digest[32*(7-i) +: 32] = h_q[i];
  end

  assign bus.block_ready_o  = (state_q == IDLE);
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.digest_valid_o = dv_q;
  assign bus.digest_o       = digest;

endmodule

// Bitwise SHA-2 choose: each result bit takes y where x is 1, else z.
module prim_generic_ch #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] x_i,
  input  logic [Width-1:0] y_i,
  input  logic [Width-1:0] z_i,
  output logic [Width-1:0] ch_o
);
  assign ch_o = (x_i & y_i) ^ (~x_i & z_i);
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed and randomized checks of sha256_round_ctrl against a plain
// SHA-256 compression function computed over a full 64-word schedule.
module tb_sha256_round_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_round_ctrl_if bus();

  sha256_round_ctrl #(.Rounds(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  localparam logic [255:0] IV_D    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_D   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] ABC_B   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_B = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  int n_assert = 0;
  int n_fail   = 0;
  int n_accept = 0;
  int n_abort  = 0;
  int n_pulse  = 0;

  always @(negedge clk) if (rst_n && bus.digest_valid_o === 1'b1) n_pulse++;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1, chv, mjv;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      chv = (v[4] & v[5]) ^ (~v[4] & v[6]);
      mjv = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + chv + KT[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + mjv;
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rand_block(output logic [511:0] blk);
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
  endtask

  // Called just after a falling edge; returns at the falling edge of round 0.
  task automatic offer(input logic [511:0] blk, input logic ini, input bit drop);
    int k = 0;
    logic [511:0] junk;
    bus.block_valid_i = 1'b1;
    bus.block_i = blk;
    bus.init_i = ini;
    while (bus.block_ready_o !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("accept_wait", 256'(k < 200), 256'(1));
    @(posedge clk);
    n_accept++;
    @(negedge clk);
    if (drop) begin
      rand_block(junk);
      bus.block_valid_i = 1'b0;
      bus.block_i = junk;
      bus.init_i = 1'($urandom);
    end
  endtask

  // Counts cycles from the accept edge; returns in the digest_valid cycle.
  task automatic wait_digest(input bit toggle);
    int cyc = 1;
    bit bad = 1'b0;
    logic [511:0] junk;
    while (bus.digest_valid_o !== 1'b1 && cyc < 200) begin
      if (bus.block_ready_o !== 1'b0 || bus.busy_o !== 1'b1) bad = 1'b1;
      if (toggle) begin
        rand_block(junk);
        bus.block_i = junk;
        bus.init_i = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    check("busy_window", 256'(bad), 256'(0));
    check("digest_latency", 256'(cyc), 256'(66));
    check("ready_at_digest", {254'(0), bus.block_ready_o, bus.busy_o}, 256'(2));
  endtask

  task automatic run(input string tag, input logic [511:0] blk, input logic ini, input logic [255:0] exp);
    offer(blk, ini, 1'b1);
    wait_digest(1'b0);
    check(tag, bus.digest_o, exp);
    @(negedge clk);
    check("single_pulse", 256'(bus.digest_valid_o), 256'(0));
    check("digest_stable", bus.digest_o, exp);
  endtask

  initial begin
    logic [511:0] blk;
    logic [255:0] h_model;
    logic [255:0] exp;
    logic ini;
    int gap;
    bit flag;

    bus.block_valid_i = 1'b0;
    bus.block_i = '0;
    bus.init_i = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_digest", bus.digest_o, IV_D);
    check("reset_flags", {253'(0), bus.block_ready_o, bus.busy_o, bus.digest_valid_o}, 256'(4));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_digest", bus.digest_o, IV_D);

    run("abc", ABC_B, 1'b1, ABC_D);
    run("empty", EMPTY_B, 1'b1, EMPTY_D);

    offer(TWO_B1, 1'b1, 1'b1);
    wait_digest(1'b0);
    check("two_block_mid", bus.digest_o, compress(IV_D, TWO_B1));
    offer(TWO_B2, 1'b0, 1'b1);
    check("b2b_no_pulse", 256'(bus.digest_valid_o), 256'(0));
    wait_digest(1'b0);
    check("two_block", bus.digest_o, TWO_D);

    offer(ABC_B, 1'b1, 1'b0);
    wait_digest(1'b1);
    check("backpressure_abc", bus.digest_o, ABC_D);
    offer(ABC_B, 1'b1, 1'b1);
    wait_digest(1'b0);
    check("abc_reinit", bus.digest_o, ABC_D);
    @(negedge clk);
    check("single_pulse_bp", 256'(bus.digest_valid_o), 256'(0));

    offer(ABC_B, 1'b0, 1'b1);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    n_abort++;
    #1;
    check("abort_digest", bus.digest_o, IV_D);
    check("abort_flags", {253'(0), bus.block_ready_o, bus.busy_o, bus.digest_valid_o}, 256'(4));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_ready", 256'(bus.block_ready_o), 256'(1));
    flag = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (bus.digest_valid_o !== 1'b0) flag = 1'b1;
    end
    check("abort_no_pulse", 256'(flag), 256'(0));
    check("abort_digest_held", bus.digest_o, IV_D);
    run("abc_after_abort", ABC_B, 1'b0, ABC_D);

    h_model = ABC_D;
    for (int n = 0; n < 20; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      rand_block(blk);
      ini = ($urandom_range(0, 3) == 0);
      if (ini) h_model = IV_D;
      exp = compress(h_model, blk);
      h_model = exp;
      offer(blk, ini, 1'b1);
      wait_digest(1'b0);
      check("random_digest", bus.digest_o, exp);
    end

    @(negedge clk);
    check("pulse_count", 256'(n_pulse), 256'(n_accept - n_abort));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end

endmodule
